mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_if.sv | 43 ++++
 rtl/mult_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_if
// Description : Handshake/data bundle between the EX/ID pipeline stages and
//               the HI/LO multiply-divide unit.
//   start     : begin an operation (honoured only while the unit is idle)
//   op        : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a     : multiplicand / dividend
//   src_b     : multiplier / divisor
//   mthi/mtlo : write wdata into HI / LO
//   mf_read   : an MFHI/MFLO sits in ID this cycle
//   busy      : operation in flight
//   stall_req : stall request toward the hazard unit
//   done      : one-cycle pulse after HI/LO were written by an operation
//   hi / lo   : architectural HI and LO registers
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        mf_read;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src_a, src_b, mthi, mtlo, wdata, mf_read,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, mthi, mtlo, wdata, mf_read,
    output busy, stall_req, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative 32x32 multiply / 32/32 divide unit owning HI/LO.
//               One start edge, 32 radix-2 steps on operand magnitudes, one
//               sign-fix cycle; HI/LO are written 33 cycles after start.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   bus       : mult_div_if.slave (start/op/operands/mthi/mtlo/wdata/mf_read
//               in; busy/stall_req/done/hi/lo out)
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit (
  input  logic       clk,
  input  logic       rst,
  mult_div_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state_q,   state_d;
  logic [4:0]  cnt_q,     cnt_d;
  logic [63:0] acc_q,     acc_d;      // product, or {remainder, quotient}
  logic [31:0] opnd_q,    opnd_d;     // multiplicand or divisor magnitude
  logic        is_div_q,  is_div_d;
  logic        neg_res_q, neg_res_d;  // negate product / quotient
  logic        neg_rem_q, neg_rem_d;  // negate remainder
  logic        div0_q,    div0_d;
  logic [31:0] hi_q,      hi_d;
  logic [31:0] lo_q,      lo_d;
  logic        done_q,    done_d;

  // Operand decode at the start edge
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.src_a[31];
  assign b_neg     = signed_op & bus.src_b[31];
  assign a_mag     = a_neg ? (32'd0 - bus.src_a) : bus.src_a;
  assign b_mag     = b_neg ? (32'd0 - bus.src_b) : bus.src_b;

  // Shift-add step: multiplier sits in acc[31:0] and is consumed LSB first
  // while the partial product grows into the upper half.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring divide step: shift the next dividend bit into the partial
  // remainder and subtract when it fits. The partial remainder never reaches
  // 2^32 after the step, so a 32-bit difference is exact.
  logic [32:0] div_r;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [31:0] div_rem;
  logic [63:0] div_next;

  assign div_r    = {acc_q[63:32], acc_q[31]};
  assign div_ge   = (div_r >= {1'b0, opnd_q});
  assign div_sub  = div_r[31:0] - opnd_q;
  assign div_rem  = div_ge ? div_sub : div_r[31:0];
  assign div_next = {div_rem, acc_q[30:0], div_ge};

  // Sign correction applied in FIX
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
  // A zero divisor always yields an all-ones quotient regardless of signs;
  // the remainder path already reproduces the dividend.
  assign quo_fix  = div0_q ? 32'hFFFF_FFFF
                  : (neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
  assign rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // An accepted start takes priority over any same-cycle mthi/mtlo.
          is_div_d  = bus.op[1];
          acc_d     = bus.op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
          opnd_d    = bus.op[1] ? b_mag : a_mag;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = bus.op[1] & a_neg;
          div0_d    = bus.op[1] & (bus.src_b == 32'd0);
          cnt_d     = 5'd31;
          state_d   = S_RUN;
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end

      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == 5'd0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN) || (state_q == S_FIX);
  // busy is low in the done cycle, so a waiting MFHI/MFLO proceeds then.
  assign bus.stall_req = bus.mf_read & (bus.busy | bus.start);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_if bus ();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.src_a   = 32'd0;
    bus.src_b   = 32'd0;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    bus.wdata   = 32'd0;
    bus.mf_read = 1'b0;
  endtask

  // Issue one operation and follow it to completion.
  // tail=0 returns in the done cycle so the caller can start back-to-back.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string name, input bit tail);
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    for (int i = 0; i < 33; i++) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: busy=%b done=%b, required busy=1 done=0", name, i + 1, bus.busy, bus.done);
      end
      n_checks++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) begin
        n_fail++;
        $display("FAIL %s hold cycle %0d: hi=%h lo=%h, required hi=%h lo=%h", name, i + 1, bus.hi, bus.lo, m_hi, m_lo);
      end
      step();
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: done=%b busy=%b, required done=1 busy=0", name, bus.done, bus.busy);
    end
    n_checks++;
    if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
      n_fail++;
      $display("FAIL %s result: hi=%h lo=%h, required hi=%h lo=%h", name, bus.hi, bus.lo, exp_hi, exp_lo);
    end
    m_hi = exp_hi;
    m_lo = exp_lo;
    if (tail) begin
      step();
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done width: done=%b, required 0", name, bus.done);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    bus.start = 1'b1;
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hFFFF_FFFF;
    step();
    step();
    step();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    rst = 1'b0;
    idle_inputs();
    bus.mf_read = 1'b1;
    #1;
    n_checks++;
    if (bus.stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: stall_req=%b, required 0", bus.stall_req);
    end
    bus.start = 1'b1;
    #1;
    n_checks++;
    if (bus.stall_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall_start: stall_req=%b, required 1", bus.stall_req);
    end
    idle_inputs();
    m_hi = 32'd0;
    m_lo = 32'd0;
    step();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_start: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_mult;
    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, "multu_max_x2", 1'b1);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3_x5", 1'b1);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_neg1_neg1", 1'b1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min_min", 1'b1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max_max", 1'b1);
  endtask

  task automatic test_div;
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2", 1'b1);
    run_op(2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by_zero", 1'b1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_neg1", 1'b1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by_zero", 1'b1);
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_neg2", 1'b1);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, "divu_max_16", 1'b1);
  endtask

  task automatic test_mt;
    bus.mthi  = 1'b1;
    bus.wdata = 32'h1234_5678;
    step();
    bus.mthi = 1'b0;
    n_checks++;
    if (bus.hi !== 32'h1234_5678 || bus.lo !== m_lo) begin
      n_fail++;
      $display("FAIL mthi: hi=%h lo=%h, required hi=12345678 lo=%h", bus.hi, bus.lo, m_lo);
    end
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hCAFE_F00D;
    step();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    n_checks++;
    if (bus.hi !== 32'hCAFE_F00D || bus.lo !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL mthi_mtlo_both: hi=%h lo=%h, required both cafef00d", bus.hi, bus.lo);
    end
    m_hi = 32'hCAFE_F00D;
    m_lo = 32'hCAFE_F00D;
  endtask

  task automatic test_start_ignored;
    bus.op    = 2'b01;
    bus.src_a = 32'd6;
    bus.src_b = 32'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (i == 9) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        bus.mthi  = 1'b1;
        bus.wdata = 32'h0000_AAAA;
      end else if (i == 10) begin
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
      end
      n_checks++;
      if (bus.busy !== 1'b1 || bus.hi !== m_hi) begin
        n_fail++;
        $display("FAIL ignore_start cycle %0d: busy=%b hi=%h, required busy=1 hi=%h", i + 1, bus.busy, bus.hi, m_hi);
      end
      step();
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
      n_fail++;
      $display("FAIL ignore_start result: done=%b hi=%h lo=%h, required done=1 hi=0 lo=2a", bus.done, bus.hi, bus.lo);
    end
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0000_0055;
    step();
    bus.mtlo = 1'b0;
    n_checks++;
    if (bus.lo !== 32'h55 || bus.hi !== 32'd0) begin
      n_fail++;
      $display("FAIL mtlo_after_op: hi=%h lo=%h, required hi=0 lo=55", bus.hi, bus.lo);
    end
    m_hi = 32'd0;
    m_lo = 32'h55;
  endtask

  task automatic test_stall;
    bus.mf_read = 1'b1;
    bus.op      = 2'b11;
    bus.src_a   = 32'd100;
    bus.src_b   = 32'd7;
    bus.start   = 1'b1;
    #1;
    n_checks++;
    if (bus.stall_req !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_at_start: stall_req=%b, required 1", bus.stall_req);
    end
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 33; i++) begin
      n_checks++;
      if (bus.stall_req !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_busy cycle %0d: stall_req=%b, required 1", i + 1, bus.stall_req);
      end
      step();
    end
    n_checks++;
    if (bus.stall_req !== 1'b0 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_done: stall_req=%b done=%b, required stall_req=0 done=1", bus.stall_req, bus.done);
    end
    n_checks++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      n_fail++;
      $display("FAIL divu_100_7: hi=%h lo=%h, required hi=2 lo=e", bus.hi, bus.lo);
    end
    m_hi = 32'd2;
    m_lo = 32'd14;
    bus.mf_read = 1'b0;
    step();
  endtask

  task automatic test_back_to_back;
    // mthi alongside an accepted start must be dropped
    bus.mthi  = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, "b2b_first", 1'b0);
    run_op(2'b00, 32'hFFFF_FFFE, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFEE, "b2b_second", 1'b1);
  endtask

  task automatic test_reset_abort;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0000_0055;
    step();
    bus.mtlo = 1'b0;
    m_lo = 32'h55;
    bus.op    = 2'b00;
    bus.src_a = 32'd3;
    bus.src_b = 32'd4;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 19; i++) step();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.lo !== 32'h55) begin
      n_fail++;
      $display("FAIL abort_pre: busy=%b lo=%h, required busy=1 lo=55", bus.busy, bus.lo);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: busy=%b hi=%h lo=%h done=%b, required all 0", bus.busy, bus.hi, bus.lo, bus.done);
    end
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.lo !== 32'd0) begin
        n_fail++;
        $display("FAIL abort_quiet cycle %0d: done=%b busy=%b lo=%h, required 0/0/0", i, bus.done, bus.busy, bus.lo);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_start_ignored();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
